// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : RV32I data-memory responder with split unaligned access
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx, idx1;
  logic [1:0]    off;
  logic [3:0]    size_mask;
  logic [7:0]    be;
  logic [63:0]   wd;
  logic          illegal, needs_split, accept;

  // Second-half context held across the SPLIT cycle
  logic [AW-1:0] lat_idx1;
  logic [3:0]    lat_be_hi;
  logic [31:0]   lat_wd_hi;
  logic          lat_we;
  logic [1:0]    lat_off;
  logic [3:0]    lat_mask;
  logic [31:0]   lat_lo;

  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic          rsp_fire, latch;
  logic [1:0]    cur_off;
  logic [3:0]    cur_mask;
  logic          cur_we;
  logic [31:0]   lo, hi, shifted, rdata_next;
  logic          unused_addr;

  always_comb begin
    case (req_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  assign idx         = req_addr[AW+1:2];
  assign idx1        = idx + AW'(1);
  assign off         = req_addr[1:0];
  assign be          = {4'b0000, size_mask} << off;
  assign wd          = {32'h0, req_wdata} << {off, 3'b000};
  assign illegal     = (size_mask == 4'b0000);
  assign needs_split = |be[7:4];
  assign unused_addr = ^req_addr[31:AW+2];

  assign req_ready = nrst & (state == IDLE);
  assign accept    = req_valid & req_ready;

  assign rd_idx  = (state == SPLIT) ? lat_idx1 : idx;
  assign rd_word = mem[rd_idx];

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_idx     = idx;
    wr_be      = be[3:0];
    wr_data    = wd[31:0];
    rsp_fire   = 1'b0;
    latch      = 1'b0;
    cur_off    = off;
    cur_mask   = size_mask;
    cur_we     = req_we;
    lo         = rd_word;
    hi         = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (needs_split) begin
            state_next = SPLIT;
            latch      = 1'b1;
            wr_en      = req_we;
          end else begin
            rsp_fire = 1'b1;
            wr_en    = req_we & ~illegal;
          end
        end
      end
      SPLIT: begin
        state_next = IDLE;
        wr_en      = lat_we;
        wr_idx     = lat_idx1;
        wr_be      = lat_be_hi;
        wr_data    = lat_wd_hi;
        rsp_fire   = 1'b1;
        cur_off    = lat_off;
        cur_mask   = lat_mask;
        cur_we     = lat_we;
        lo         = lat_lo;
        hi         = rd_word;
      end
      default: state_next = IDLE;
    endcase
  end

  assign shifted    = 32'({hi, lo} >> {cur_off, 3'b000});
  assign rdata_next = (cur_we || cur_mask == 4'b0000) ? 32'h0 :
                      shifted & {{8{cur_mask[3]}}, {8{cur_mask[2]}},
                                 {8{cur_mask[1]}}, {8{cur_mask[0]}}};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_idx1  <= '0;
      lat_be_hi <= 4'h0;
      lat_wd_hi <= 32'h0;
      lat_we    <= 1'b0;
      lat_off   <= 2'b00;
      lat_mask  <= 4'h0;
      lat_lo    <= 32'h0;
    end else begin
      state     <= state_next;
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_rdata <= rdata_next;
        rsp_err   <= ~|cur_mask;
      end
      if (latch) begin
        lat_idx1  <= idx1;
        lat_be_hi <= be[7:4];
        lat_wd_hi <= wd[63:32];
        lat_we    <= req_we;
        lat_off   <= off;
        lat_mask  <= size_mask;
        lat_lo    <= rd_word;
      end
    end
  end

  // Storage is deliberately not reset; only enabled byte lanes change
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed self-checking bench for dmem_responder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        sel;

  logic        rdy0, rv0, er0, rdy4, rv4, er4;
  logic [31:0] rd0, rd4;
  logic        ready, rvalid, rerr;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024)) u_dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
  );

  dmem_responder #(.DEPTH_WORDS(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .req_valid(req_valid & sel), .req_ready(rdy4),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(er4)
  );

  assign ready  = sel ? rdy4 : rdy0;
  assign rvalid = sel ? rv4  : rv0;
  assign rerr   = sel ? er4  : er0;
  assign rdata  = sel ? rd4  : rd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request; lat counts edges from accept to response, rdy_low the cycles ready was low
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wdat,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int rdy_low);
    int guard;
    rd = 32'h0; er = 1'b0; lat = 0; rdy_low = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wdat;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      check({tag, "_ready_tmo"}, {31'h0, ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (lat < 8) begin
      lat++;
      if (!ready) rdy_low++;
      if (rvalid) begin
        rd = rdata;
        er = rerr;
        return;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_rsp_tmo"}, {31'h0, rvalid}, 32'h1);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wdat, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat, rl;
    do_req(tag, 1'b1, sz, a, wdat, rd, er, lat, rl);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdylow"}, rl, (exp_lat == 2) ? 1 : 0);
    check({tag, "_rdata"}, rd, 32'h0);
    check({tag, "_err"}, {31'h0, er}, 32'h0);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] exp_data, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat, rl;
    do_req(tag, 1'b0, sz, a, 32'h0, rd, er, lat, rl);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdylow"}, rl, (exp_lat == 2) ? 1 : 0);
    check({tag, "_rdata"}, rd, exp_data);
    check({tag, "_err"}, {31'h0, er}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, rl;

    nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; sel = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {31'h0, ready},  32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_rdata",  rdata,           32'h0);
    check("rst_err",    {31'h0, rerr},   32'h0);
    @(negedge clk) nrst = 1'b1;
    #1 check("rel_ready", {31'h0, ready}, 32'h1);

    // Aligned word
    store("st_w10", 2'b10, 32'h10, 32'hDEADBEEF, 1);
    load ("ld_w10", 2'b10, 32'h10, 32'hDEADBEEF, 1);

    // Byte lanes; upper store-data bits must be ignored
    store("st_w20", 2'b10, 32'h20, 32'h11223344, 1);
    store("st_b21", 2'b00, 32'h21, 32'h555555AA, 1);
    load ("ld_w20", 2'b10, 32'h20, 32'h1122AA44, 1);
    load ("ld_b21", 2'b00, 32'h21, 32'h000000AA, 1);
    load ("ld_h22", 2'b01, 32'h22, 32'h00001122, 1);

    // Split word
    store("st_z0c", 2'b10, 32'h0C, 32'h0, 1);
    store("st_z10", 2'b10, 32'h10, 32'h0, 1);
    store("st_w0e", 2'b10, 32'h0E, 32'hCAFEF00D, 2);
    load ("ld_w0e", 2'b10, 32'h0E, 32'hCAFEF00D, 2);
    load ("ld_w0c", 2'b10, 32'h0C, 32'hF00D0000, 1);
    load ("ld_w10b", 2'b10, 32'h10, 32'h0000CAFE, 1);

    // Wrap on the 4-word instance
    sel = 1'b1;
    store("w4_z0c", 2'b10, 32'h0C, 32'h0, 1);
    store("w4_z00", 2'b10, 32'h00, 32'h0, 1);
    store("w4_h0f", 2'b01, 32'h0F, 32'hBEEF, 2);
    load ("w4_w0c", 2'b10, 32'h0C, 32'hEF000000, 1);
    load ("w4_w00", 2'b10, 32'h00, 32'h000000BE, 1);
    load ("w4_h0f", 2'b01, 32'h0F, 32'h0000BEEF, 2);
    load ("w4_alias", 2'b10, 32'h1C, 32'hEF000000, 1);
    sel = 1'b0;

    // Illegal size
    store("st_w40", 2'b10, 32'h40, 32'hA5A5A5A5, 1);
    do_req("ill_st", 1'b1, 2'b11, 32'h40, 32'h12345678, rd, er, lat, rl);
    check("ill_st_err",   {31'h0, er}, 32'h1);
    check("ill_st_rdata", rd, 32'h0);
    check("ill_st_lat",   lat, 1);
    load ("ld_w40", 2'b10, 32'h40, 32'hA5A5A5A5, 1);
    do_req("ill_ld", 1'b0, 2'b11, 32'h43, 32'h0, rd, er, lat, rl);
    check("ill_ld_err", {31'h0, er}, 32'h1);
    check("ill_ld_lat", lat, 1);
    check("ill_ld_rdy", rl, 0);

    // Back-to-back store then load of the same word
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h50;
    req_wdata = 32'h13579BDF;
    @(posedge clk);
    #1;
    check("b2b_rdy",    {31'h0, ready},  32'h1);
    check("b2b_st_vld", {31'h0, rvalid}, 32'h1);
    req_we = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b_ld_vld",  {31'h0, rvalid}, 32'h1);
    check("b2b_ld_data", rdata, 32'h13579BDF);
    @(posedge clk);
    #1 check("b2b_idle_vld", {31'h0, rvalid}, 32'h0);

    // Reset during SPLIT of a store
    store("st_z00", 2'b10, 32'h00, 32'h0, 1);
    store("st_w04", 2'b10, 32'h04, 32'h12345678, 1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h03;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("ms_split_rdy", {31'h0, ready}, 32'h0);
    #1 nrst = 1'b0;
    #1;
    check("ms_rst_rdy", {31'h0, ready},  32'h0);
    check("ms_rst_vld", {31'h0, rvalid}, 32'h0);
    @(posedge clk);
    #1 check("ms_edge_vld", {31'h0, rvalid}, 32'h0);
    @(negedge clk) nrst = 1'b1;
    #1 check("ms_rel_rdy", {31'h0, ready}, 32'h1);
    @(posedge clk);
    #1 check("ms_post_vld", {31'h0, rvalid}, 32'h0);
    load ("ms_w00", 2'b10, 32'h00, 32'hFF000000, 1);
    load ("ms_w04", 2'b10, 32'h04, 32'h12345678, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
